// File: rtl/goomba_contact_resolver.sv
// Goomba life cycle (alive/squished/gone) and Mario contact resolution: stomp vs hit, with hit cooldown.
// Optional respawn from GONE is enabled by defining GOOMBA_RESPAWN_EN.
module goomba_contact_resolver #(
    parameter int CHARACTER_WIDTH  = 42,
    parameter int CHARACTER_HEIGHT = 40,
    parameter int STOMP_MARGIN     = 12,
    parameter int SQUISH_TICKS     = 30,
    parameter int INVULN_TICKS     = 60,
    parameter int RESPAWN_TICKS    = 120
) (
    input  logic        vga_clock,
    input  logic        reset,
    input  logic        movement_tick,
    input  logic [31:0] mario_x,
    input  logic [31:0] mario_y,
    input  logic        mario_falling,
    input  logic [31:0] goomba_x,
    input  logic [31:0] goomba_y,
    output logic        goomba_visible,
    output logic        squish_active,
    output logic        stomp_pulse,
    output logic        hit_pulse,
    output logic        invulnerable,
    output logic [7:0]  stomp_count
);

    localparam int SQ_W  = $clog2(SQUISH_TICKS + 1);
    localparam int INV_W = $clog2(INVULN_TICKS + 1);

    typedef enum logic [1:0] {
        ALIVE    = 2'd0,
        SQUISHED = 2'd1,
        GONE     = 2'd2
    } life_state_t;

    life_state_t        state, state_next;
    logic [SQ_W-1:0]    sq_cnt, sq_next;
    logic [INV_W-1:0]   inv_cnt, inv_next;
    logic               invuln_next, stomp_next, hit_next;
    logic [7:0]         count_next;

    logic signed [32:0] dx, dy, abs_dx, abs_dy;
    logic signed [33:0] mario_bottom, stomp_line;
    logic               overlap, stomp_cond;

    // Signed differences are widened by one bit so no coordinate pair can overflow
    always_comb begin
        dx           = $signed({mario_x[31], mario_x}) - $signed({goomba_x[31], goomba_x});
        dy           = $signed({mario_y[31], mario_y}) - $signed({goomba_y[31], goomba_y});
        abs_dx       = dx[32] ? -dx : dx;
        abs_dy       = dy[32] ? -dy : dy;
        mario_bottom = $signed({{2{mario_y[31]}}, mario_y}) + 34'(CHARACTER_HEIGHT);
        stomp_line   = $signed({{2{goomba_y[31]}}, goomba_y}) + 34'(STOMP_MARGIN);
        overlap      = (abs_dx < 33'(CHARACTER_WIDTH)) && (abs_dy < 33'(CHARACTER_HEIGHT));
        stomp_cond   = overlap && mario_falling && (mario_bottom <= stomp_line);
    end

`ifdef GOOMBA_RESPAWN_EN
    localparam int RESP_W = $clog2(RESPAWN_TICKS + 1);
    logic [RESP_W-1:0]  gone_cnt, gone_next;
`endif

    always_comb begin
        state_next  = state;
        sq_next     = sq_cnt;
        inv_next    = inv_cnt;
        invuln_next = invulnerable;
        stomp_next  = 1'b0;
        hit_next    = 1'b0;
        count_next  = stomp_count;
`ifdef GOOMBA_RESPAWN_EN
        gone_next   = gone_cnt;
`endif
        if (movement_tick) begin
            // Cooldown ages on every tick regardless of life state
            if (invulnerable) begin
                if (inv_cnt == INV_W'(INVULN_TICKS - 1)) begin
                    invuln_next = 1'b0;
                    inv_next    = '0;
                end else begin
                    inv_next = inv_cnt + 1'b1;
                end
            end
            case (state)
                ALIVE: begin
                    if (stomp_cond) begin
                        state_next = SQUISHED;
                        stomp_next = 1'b1;
                        sq_next    = '0;
                        if (stomp_count != 8'hFF) count_next = stomp_count + 8'd1;
                    end else if (overlap && !invulnerable) begin
                        hit_next    = 1'b1;
                        invuln_next = 1'b1;
                        inv_next    = '0;
                    end
                end
                SQUISHED: begin
                    if (sq_cnt == SQ_W'(SQUISH_TICKS - 1)) begin
                        state_next = GONE;
                        sq_next    = '0;
`ifdef GOOMBA_RESPAWN_EN
                        gone_next  = '0;
`endif
                    end else begin
                        sq_next = sq_cnt + 1'b1;
                    end
                end
                GONE: begin
`ifdef GOOMBA_RESPAWN_EN
                    if (gone_cnt == RESP_W'(RESPAWN_TICKS - 1)) begin
                        state_next = ALIVE;
                        gone_next  = '0;
                    end else begin
                        gone_next = gone_cnt + 1'b1;
                    end
`else
                    state_next = GONE;
`endif
                end
                default: state_next = ALIVE;
            endcase
        end
    end

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            state        <= ALIVE;
            sq_cnt       <= '0;
            inv_cnt      <= '0;
            invulnerable <= 1'b0;
            stomp_pulse  <= 1'b0;
            hit_pulse    <= 1'b0;
            stomp_count  <= 8'd0;
`ifdef GOOMBA_RESPAWN_EN
            gone_cnt     <= '0;
`endif
        end else begin
            state        <= state_next;
            sq_cnt       <= sq_next;
            inv_cnt      <= inv_next;
            invulnerable <= invuln_next;
            stomp_pulse  <= stomp_next;
            hit_pulse    <= hit_next;
            stomp_count  <= count_next;
`ifdef GOOMBA_RESPAWN_EN
            gone_cnt     <= gone_next;
`endif
        end
    end

    assign goomba_visible = (state != GONE);
    assign squish_active  = (state == SQUISHED);

endmodule

// File: tb/tb_goomba_contact_resolver.sv
// Table-driven bench for goomba_contact_resolver plus directed squish, cooldown, reset and GONE sequences.
// Respawn expectations follow GOOMBA_RESPAWN_EN when it is defined.
module tb_goomba_contact_resolver;

    logic        vga_clock;
    logic        reset;
    logic        movement_tick;
    logic [31:0] mario_x, mario_y, goomba_x, goomba_y;
    logic        mario_falling;
    logic        goomba_visible, squish_active, stomp_pulse, hit_pulse, invulnerable;
    logic [7:0]  stomp_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] mx;
        logic [31:0] my;
        logic        falling;
        logic        tick;
        logic        exp_hit;
        logic        exp_stomp;
        logic        exp_vis;
        logic        exp_squish;
        logic        exp_inv;
        logic [7:0]  exp_count;
    } vec_t;

    vec_t vecs[10];

    goomba_contact_resolver dut (
        .vga_clock      (vga_clock),
        .reset          (reset),
        .movement_tick  (movement_tick),
        .mario_x        (mario_x),
        .mario_y        (mario_y),
        .mario_falling  (mario_falling),
        .goomba_x       (goomba_x),
        .goomba_y       (goomba_y),
        .goomba_visible (goomba_visible),
        .squish_active  (squish_active),
        .stomp_pulse    (stomp_pulse),
        .hit_pulse      (hit_pulse),
        .invulnerable   (invulnerable),
        .stomp_count    (stomp_count)
    );

    initial vga_clock = 1'b0;
    always #5 vga_clock = ~vga_clock;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual %0d required %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs; outputs are sampled 1 time unit after the edge that consumed them
    task automatic apply_stimulus(input logic [31:0] mx, input logic [31:0] my, input logic falling, input logic tick);
        @(negedge vga_clock);
        mario_x       = mx;
        mario_y       = my;
        mario_falling = falling;
        movement_tick = tick;
        @(posedge vga_clock);
        #1;
        movement_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge vga_clock);
        reset         = 1'b0;
        movement_tick = 1'b0;
        repeat (2) @(negedge vga_clock);
        reset = 1'b1;
    endtask

    initial begin
        reset         = 1'b0;
        movement_tick = 1'b0;
        mario_x       = 32'd0;
        mario_y       = 32'd0;
        mario_falling = 1'b0;
        goomba_x      = 32'd300;
        goomba_y      = 32'd360;

        //              mx    my   fall tick  hit stmp vis sq  inv cnt
        vecs[0] = '{32'd0,   32'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[1] = '{32'd342, 32'd360, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[2] = '{32'd300, 32'd400, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[3] = '{32'd258, 32'd360, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[4] = '{32'd280, 32'd360, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[5] = '{32'd341, 32'd399, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
        vecs[6] = '{32'd341, 32'd399, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
        vecs[7] = '{32'd280, 32'd360, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
        vecs[8] = '{32'd290, 32'd330, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1};
        vecs[9] = '{32'd290, 32'd330, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1};

        #1;
        check_output("reset_visible", 32'(goomba_visible), 32'd1);
        check_output("reset_squish", 32'(squish_active), 32'd0);
        check_output("reset_count", 32'(stomp_count), 32'd0);
        check_output("reset_inv", 32'(invulnerable), 32'd0);
        repeat (2) @(negedge vga_clock);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].mx, vecs[i].my, vecs[i].falling, vecs[i].tick);
            check_output($sformatf("vec%0d_hit", i), 32'(hit_pulse), 32'(vecs[i].exp_hit));
            check_output($sformatf("vec%0d_stomp", i), 32'(stomp_pulse), 32'(vecs[i].exp_stomp));
            check_output($sformatf("vec%0d_visible", i), 32'(goomba_visible), 32'(vecs[i].exp_vis));
            check_output($sformatf("vec%0d_squish", i), 32'(squish_active), 32'(vecs[i].exp_squish));
            check_output($sformatf("vec%0d_inv", i), 32'(invulnerable), 32'(vecs[i].exp_inv));
            check_output($sformatf("vec%0d_count", i), 32'(stomp_count), 32'(vecs[i].exp_count));
        end

        // Cooldown: Mario bottom 373 is one past the stomp line 372, so this is a hit
        do_reset();
        apply_stimulus(32'd290, 32'd333, 1'b1, 1'b1);
        check_output("cool_first_hit", 32'(hit_pulse), 32'd1);
        check_output("cool_first_stomp", 32'(stomp_pulse), 32'd0);
        check_output("cool_first_inv", 32'(invulnerable), 32'd1);
        for (int i = 1; i <= 59; i++) begin
            apply_stimulus(32'd290, 32'd333, 1'b1, 1'b1);
            check_output($sformatf("cool_tick%0d_hit", i), 32'(hit_pulse), 32'd0);
            check_output($sformatf("cool_tick%0d_inv", i), 32'(invulnerable), 32'd1);
        end
        apply_stimulus(32'd290, 32'd333, 1'b1, 1'b1);
        check_output("cool_tick60_hit", 32'(hit_pulse), 32'd0);
        check_output("cool_tick60_inv", 32'(invulnerable), 32'd0);
        apply_stimulus(32'd290, 32'd333, 1'b1, 1'b1);
        check_output("cool_rehit", 32'(hit_pulse), 32'd1);
        check_output("cool_rehit_inv", 32'(invulnerable), 32'd1);

        // Stomp exactly on the margin, then a continuously held tick drives the squish timer
        do_reset();
        apply_stimulus(32'd290, 32'd332, 1'b1, 1'b1);
        check_output("margin_stomp", 32'(stomp_pulse), 32'd1);
        check_output("margin_hit", 32'(hit_pulse), 32'd0);
        check_output("margin_squish", 32'(squish_active), 32'd1);
        @(negedge vga_clock);
        mario_x       = 32'd0;
        mario_y       = 32'd0;
        mario_falling = 1'b0;
        movement_tick = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge vga_clock);
            #1;
            if (i == 30) movement_tick = 1'b0;
            check_output($sformatf("squish_tick%0d_visible", i), 32'(goomba_visible), (i < 30) ? 32'd1 : 32'd0);
            check_output($sformatf("squish_tick%0d_squish", i), 32'(squish_active), (i < 30) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(32'd290, 32'd330, 1'b1, 1'b1);
            check_output($sformatf("gone%0d_stomp", i), 32'(stomp_pulse), 32'd0);
            check_output($sformatf("gone%0d_hit", i), 32'(hit_pulse), 32'd0);
            check_output($sformatf("gone%0d_visible", i), 32'(goomba_visible), 32'd0);
        end
`ifdef GOOMBA_RESPAWN_EN
        repeat (114) apply_stimulus(32'd0, 32'd0, 1'b0, 1'b1);
        check_output("respawn_tick119_visible", 32'(goomba_visible), 32'd0);
        apply_stimulus(32'd0, 32'd0, 1'b0, 1'b1);
        check_output("respawn_tick120_visible", 32'(goomba_visible), 32'd1);
        check_output("respawn_squish", 32'(squish_active), 32'd0);
        check_output("respawn_count_kept", 32'(stomp_count), 32'd1);
`else
        repeat (495) apply_stimulus(32'd0, 32'd0, 1'b0, 1'b1);
        check_output("terminal_gone_visible", 32'(goomba_visible), 32'd0);
        check_output("terminal_gone_count", 32'(stomp_count), 32'd1);
`endif

        // Asynchronous reset in the middle of the squish
        do_reset();
        apply_stimulus(32'd290, 32'd330, 1'b1, 1'b1);
        check_output("abort_stomp", 32'(stomp_pulse), 32'd1);
        repeat (12) apply_stimulus(32'd0, 32'd0, 1'b0, 1'b1);
        check_output("abort_pre_squish", 32'(squish_active), 32'd1);
        check_output("abort_pre_count", 32'(stomp_count), 32'd1);
        @(negedge vga_clock);
        #2;
        reset = 1'b0;
        #1;
        check_output("abort_visible", 32'(goomba_visible), 32'd1);
        check_output("abort_squish", 32'(squish_active), 32'd0);
        check_output("abort_count", 32'(stomp_count), 32'd0);
        @(negedge vga_clock);
        reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
